// File: rtl/uart_peek_cmd_parser.sv
// UART peek command parser: 5-byte rx frame -> core peek request -> 4-byte tx reply.
// Optional PEEK_TIMEOUT_EN discards partial frames after TIMEOUT_CYCLES idle cycles.
`timescale 1ns/1ps
module uart_peek_cmd_parser #(
  parameter int CORE_COUNT     = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [7:0]        req_id,
  output logic [31:0]       req_addr,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              rx_overrun,
  output logic              err_bad_id,
  output logic              frame_timeout
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_peek_cmd_parser: unsupported parameters");
  end

  typedef enum logic [1:0] {
    S_COLLECT,
    S_REQ,
    S_WAIT,
    S_SEND
  } state_e;

  localparam logic [8:0] CC = 9'(CORE_COUNT);

  state_e            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       addr_buf_q, addr_buf_d;
  logic [7:0]        req_id_q, req_id_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        k_q, k_d;
  logic              ovr_q, ovr_d;
  logic              bad_q, bad_d;
  logic              to_q, to_d;

`ifdef PEEK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_q, idle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      byte_cnt_q <= '0;
      addr_buf_q <= '0;
      req_id_q   <= '0;
      req_addr_q <= '0;
      result_q   <= '0;
      k_q        <= '0;
      ovr_q      <= 1'b0;
      bad_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_buf_q <= addr_buf_d;
      req_id_q   <= req_id_d;
      req_addr_q <= req_addr_d;
      result_q   <= result_d;
      k_q        <= k_d;
      ovr_q      <= ovr_d;
      bad_q      <= bad_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_buf_d = addr_buf_q;
    req_id_d   = req_id_q;
    req_addr_d = req_addr_q;
    result_d   = result_q;
    k_d        = k_q;
    bad_d      = 1'b0;
    to_d       = 1'b0;
    ovr_d      = rx_valid && (state_q != S_COLLECT);
    unique case (state_q)
      S_COLLECT: begin
        if (rx_valid) begin
          if (byte_cnt_q == 3'd4) begin
            req_addr_d = addr_buf_q;
            req_id_d   = rx_data;
            byte_cnt_d = '0;
            k_d        = '0;
            if ({1'b0, rx_data} >= CC) begin
              bad_d    = 1'b1;
              result_d = '1;
              state_d  = S_SEND;
            end else begin
              state_d  = S_REQ;
            end
          end else begin
            // addr arrives LSB byte first, so shift in from the top
            addr_buf_d = {rx_data, addr_buf_q[31:8]};
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      S_REQ: begin
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid) begin
          result_d = resp_data;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
`ifdef PEEK_TIMEOUT_EN
    idle_d = '0;
    if (state_q == S_COLLECT && byte_cnt_q != '0 && !rx_valid) begin
      if (idle_q == TO_MAX) begin
        byte_cnt_d = '0;
        to_d       = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    req_valid = (state_q == S_REQ);
    tx_valid  = (state_q == S_SEND);
    busy      = (state_q != S_COLLECT);
    tx_data   = '0;
    if (state_q == S_SEND) tx_data = result_q[{k_q, 3'b000} +: 8];
  end

  assign req_id        = req_id_q;
  assign req_addr      = req_addr_q;
  assign rx_overrun    = ovr_q;
  assign err_bad_id    = bad_q;
  assign frame_timeout = to_q;

endmodule

// File: tb/tb_uart_peek_cmd_parser.sv
// Scoreboard bench for uart_peek_cmd_parser: random frames vs a frame-level model.
// Build with PEEK_TIMEOUT_EN to exercise the partial-frame timeout.
`timescale 1ns/1ps
module tb_uart_peek_cmd_parser;

`ifdef PEEK_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65536;
`endif

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        req_valid, req_ready;
  logic [7:0]  req_id;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        busy, rx_overrun, err_bad_id, frame_timeout;

  uart_peek_cmd_parser #(
    .CORE_COUNT(4), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .rx_overrun(rx_overrun),
    .err_bad_id(err_bad_id), .frame_timeout(frame_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
  } req_t;

  req_t        exp_req[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] resp_q[$];
  int pend;
  int checks, passed;
  int n_bad, n_ovr, n_to;
  int exp_bad, exp_ovr, exp_to;
  int stall_cnt;
  bit stall_tx;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask

  // monitor: every presented req/tx beat is compared with the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid) begin
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          chk("req_id", {56'd0, req_id}, {56'd0, exp_req[0].id});
          chk("req_addr", {32'd0, req_addr}, {32'd0, exp_req[0].addr});
          if (req_ready) begin
            exp_req.delete(0);
            pend++;
          end
        end
      end
      if (tx_valid) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx[0]});
          if (tx_ready) exp_tx.delete(0);
        end
      end
      if (err_bad_id) n_bad++;
      if (rx_overrun) n_ovr++;
      if (frame_timeout) n_to++;
    end
  end

  always begin
    @(posedge clk); #1;
    if (stall_cnt > 0) begin
      req_ready = 1'b0;
      if (req_valid) stall_cnt--;
    end else begin
      req_ready = ($urandom % 3) != 0;
    end
    tx_ready = stall_tx ? 1'b0 : (($urandom % 3) == 0);
  end

  always begin
    @(posedge clk); #1;
    resp_valid = 1'b0;
    if (pend > 0 && resp_q.size() > 0 && ($urandom % 4) == 0) begin
      resp_valid = 1'b1;
      resp_data  = resp_q.pop_front();
      pend--;
    end
  end

  // caller is always at posedge+1
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, maxgap)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [7:0] id,
                          input logic [31:0] data);
    logic [31:0] w;
    if (id < 8'd4) begin
      exp_req.push_back('{id, addr});
      resp_q.push_back(data);
      w = data;
    end else begin
      exp_bad++;
      w = 32'hFFFF_FFFF;
    end
    for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [7:0] id,
                            input logic [31:0] data, input int lastgap);
    push_exp(addr, id, data);
    for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8], 2);
    send_byte(id, lastgap);
  endtask

  // mode 0: no overrun, 1: maybe one, 2: one at once
  task automatic wait_idle(input int mode);
    bit ok, inj;
    ok = 0;
    inj = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      if (!inj && (mode == 2 || (mode == 1 && ($urandom % 4) == 0))) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        exp_ovr++;
        inj = 1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    chk("frame_done", {63'd0, ok}, 64'd1);
    chk("tx_drained", 64'(exp_tx.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  id;
    checks = 0; passed = 0; pend = 0;
    n_bad = 0; n_ovr = 0; n_to = 0;
    exp_bad = 0; exp_ovr = 0; exp_to = 0;
    stall_cnt = 0; stall_tx = 0;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    req_ready = 1'b0; tx_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {14'd0, req_valid, tx_valid, busy, rx_overrun, err_bad_id,
         frame_timeout, req_id, req_addr, tx_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // basic command with a 10-cycle req_ready stall
    stall_cnt = 10;
    send_frame(32'h0000_023C, 8'd3, 32'hA1B2_C3D4, 0);
    chk("req_latency", {63'd0, req_valid}, 64'd1);
    wait_idle(0);

    // out-of-range id: no request, all-ones reply
    send_frame(32'h0000_0268, 8'd7, 32'h0, 0);
    chk("bad_no_req", {63'd0, req_valid}, 64'd0);
    chk("bad_tx", {63'd0, tx_valid}, 64'd1);
    wait_idle(0);

    // rx byte while busy is dropped and flagged
    send_frame(32'h0000_023C, 8'd1, $urandom, 2);
    wait_idle(2);
    send_frame(32'h0000_023D, 8'd1, $urandom, 2);
    wait_idle(0);

    // idle gap inside a frame
    a = $urandom;
    d = $urandom;
    send_byte(a[7:0], 0);
    send_byte(a[15:8], 0);
    repeat (40) begin
      @(posedge clk); #1;
    end
`ifdef PEEK_TIMEOUT_EN
    exp_to++;
    send_frame(a, 8'd2, d, 2);
`else
    push_exp(a, 8'd2, d);
    send_byte(a[23:16], 2);
    send_byte(a[31:24], 2);
    send_byte(8'd2, 2);
`endif
    wait_idle(0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      d  = $urandom;
      id = 8'($urandom_range(0, 5));
      send_frame(a, id, d, 2);
      wait_idle(1);
    end

    // reset during SEND aborts the reply
    stall_tx = 1;
    send_frame($urandom, 8'd2, $urandom, 0);
    for (int c = 0; c < 500 && !tx_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("reach_send", {63'd0, tx_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    exp_tx.delete();
    exp_req.delete();
    resp_q.delete();
    pend = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall_tx = 0;
    send_frame($urandom, 8'd0, $urandom, 2);
    wait_idle(0);

    repeat (5) @(posedge clk);
    #1;
    chk("req_drained", 64'(exp_req.size()), 64'd0);
    chk("bad_count", 64'(n_bad), 64'(exp_bad));
    chk("ovr_count", 64'(n_ovr), 64'(exp_ovr));
    chk("timeout_count", 64'(n_to), 64'(exp_to));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
